packetizer_burst: RTL

PACKETIZER_BURST -- requirements
Module: packetizer_burst

---
 rtl/packetizer_burst.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/packetizer_burst.sv
// Stream packetizer with an AXI4-Lite control port.
// Passes samples straight from the source to the S2MM manager while running,
// marks every LENGTH-th beat with tlast, and stops after NUM_PACKETS packets
// (or runs forever when NUM_PACKETS is 0) or after an ABORT drains the
// packet in flight.
module packetizer_burst #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32,
    parameter int ITER_WIDTH = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
    input  logic                  s_axis_data_tvalid,
    output logic                  s_axis_data_tready,
    output logic [DATA_WIDTH-1:0] m_axis_s2mm_tdata,
    output logic                  m_axis_s2mm_tvalid,
    input  logic                  m_axis_s2mm_tready,
    output logic                  m_axis_s2mm_tlast,
    output logic                  last,
    output logic                  busy,
    input  logic [31:0]           s_axi_lite_awaddr,
    input  logic [2:0]            s_axi_lite_awprot,
    input  logic                  s_axi_lite_awvalid,
    output logic                  s_axi_lite_awready,
    input  logic [31:0]           s_axi_lite_wdata,
    input  logic [3:0]            s_axi_lite_wstrb,
    input  logic                  s_axi_lite_wvalid,
    output logic                  s_axi_lite_wready,
    output logic [1:0]            s_axi_lite_bresp,
    output logic                  s_axi_lite_bvalid,
    input  logic                  s_axi_lite_bready,
    input  logic [31:0]           s_axi_lite_araddr,
    input  logic [2:0]            s_axi_lite_arprot,
    input  logic                  s_axi_lite_arvalid,
    output logic                  s_axi_lite_arready,
    output logic [31:0]           s_axi_lite_rdata,
    output logic [1:0]            s_axi_lite_rresp,
    output logic                  s_axi_lite_rvalid,
    input  logic                  s_axi_lite_rready
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Word addresses (byte address bits 29:2)
    localparam logic [27:0] A_LENGTH = 28'h80;
    localparam logic [27:0] A_PKT    = 28'h81;
    localparam logic [27:0] A_ITER   = 28'h82;
    localparam logic [27:0] A_NUM    = 28'h83;
    localparam logic [27:0] A_CTRL   = 28'h84;

    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;
    localparam logic [ITER_WIDTH-1:0] ITER_ONE = 1;

    logic [0:0]            state;
    logic                  run;
    logic [CNT_WIDTH-1:0]  length_q;
    logic [CNT_WIDTH-1:0]  num_packets_q;
    logic [CNT_WIDTH-1:0]  pkt_cnt;
    logic [ITER_WIDTH-1:0] iter_cnt;
    logic                  done_q;
    logic                  abort_pending;
    logic                  last_flag;
    logic                  ready_en;

    logic                  aw_held;
    logic                  w_held;
    logic [27:0]           aw_word_q;
    logic [31:0]           w_data_q;
    logic [3:0]            w_strb_q;

    logic                  beat;
    logic                  beat_last;
    logic [ITER_WIDTH-1:0] iter_inc;
    logic [CNT_WIDTH-1:0]  pkt_inc;
    logic [CNT_WIDTH-1:0]  len_m1;
    logic                  finish_n;
    logic                  wr_fire;
    logic [31:0]           length_wr;
    logic [31:0]           num_wr;
    logic [31:0]           rd_data;
    logic [1:0]            rd_resp;
    logic                  unused_inputs;

    // Merge a 32-bit write into an existing value byte by byte
    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

    assign unused_inputs = ^{s_axi_lite_awprot, s_axi_lite_arprot,
                             s_axi_lite_awaddr[31:30], s_axi_lite_awaddr[1:0],
                             s_axi_lite_araddr[31:30], s_axi_lite_araddr[1:0]};

    assign run = (state == ST_RUN);

    assign m_axis_s2mm_tdata  = run ? s_axis_data_tdata : '0;
    assign m_axis_s2mm_tvalid = run & s_axis_data_tvalid;
    assign s_axis_data_tready = run & m_axis_s2mm_tready;
    assign m_axis_s2mm_tlast  = run & m_axis_s2mm_tvalid & last_flag;
    assign last               = m_axis_s2mm_tlast;
    assign busy               = run;

    assign beat      = m_axis_s2mm_tvalid & m_axis_s2mm_tready;
    assign beat_last = beat & last_flag;
    assign iter_inc  = iter_cnt + ITER_ONE;
    assign pkt_inc   = pkt_cnt + CNT_ONE;
    assign len_m1    = length_q - CNT_ONE;
    assign finish_n  = beat_last & (num_packets_q != '0) &
                       (32'(iter_inc) == 32'(num_packets_q));

    assign s_axi_lite_awready = ready_en & ~aw_held & ~s_axi_lite_bvalid;
    assign s_axi_lite_wready  = ready_en & ~w_held & ~s_axi_lite_bvalid;
    assign s_axi_lite_arready = ready_en & ~s_axi_lite_rvalid;

    assign wr_fire   = aw_held & w_held & ~s_axi_lite_bvalid;
    assign length_wr = apply_strb(32'(length_q), w_data_q, w_strb_q);
    assign num_wr    = apply_strb(32'(num_packets_q), w_data_q, w_strb_q);

    // Keep the AXI4-Lite ready outputs low until the first edge after reset release
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) ready_en <= 1'b0;
        else          ready_en <= 1'b1;
    end

    // Capture write address and write data independently until both are present
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_word_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (s_axi_lite_awvalid && s_axi_lite_awready) begin
                aw_held   <= 1'b1;
                aw_word_q <= s_axi_lite_awaddr[29:2];
            end
            if (s_axi_lite_wvalid && s_axi_lite_wready) begin
                w_held   <= 1'b1;
                w_data_q <= s_axi_lite_wdata;
                w_strb_q <= s_axi_lite_wstrb;
            end
            if (wr_fire) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    // Run/idle control, packet counters, config registers and write response
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state             <= ST_IDLE;
            length_q          <= '0;
            num_packets_q     <= '0;
            pkt_cnt           <= '0;
            iter_cnt          <= '0;
            done_q            <= 1'b0;
            abort_pending     <= 1'b0;
            last_flag         <= 1'b0;
            s_axi_lite_bvalid <= 1'b0;
            s_axi_lite_bresp  <= RESP_OKAY;
        end else begin
            if (s_axi_lite_bvalid && s_axi_lite_bready) s_axi_lite_bvalid <= 1'b0;

            if (beat) begin
                if (last_flag) begin
                    pkt_cnt   <= '0;
                    iter_cnt  <= iter_inc;
                    last_flag <= (length_q == CNT_ONE);
                    if (finish_n || abort_pending) begin
                        state         <= ST_IDLE;
                        abort_pending <= 1'b0;
                        if (finish_n) done_q <= 1'b1;
                    end
                end else begin
                    pkt_cnt   <= pkt_inc;
                    last_flag <= (pkt_inc == len_m1);
                end
            end

            if (wr_fire) begin
                s_axi_lite_bvalid <= 1'b1;
                s_axi_lite_bresp  <= RESP_OKAY;
                case (aw_word_q)
                    A_LENGTH: begin
                        if (run) s_axi_lite_bresp <= RESP_SLVERR;
                        else     length_q <= length_wr[CNT_WIDTH-1:0];
                    end
                    A_NUM: begin
                        if (run) s_axi_lite_bresp <= RESP_SLVERR;
                        else     num_packets_q <= num_wr[CNT_WIDTH-1:0];
                    end
                    A_CTRL: begin
                        if (!run) begin
                            if (w_data_q[0]) begin
                                if (length_q == '0) begin
                                    s_axi_lite_bresp <= RESP_SLVERR;
                                end else begin
                                    state         <= ST_RUN;
                                    pkt_cnt       <= '0;
                                    iter_cnt      <= '0;
                                    done_q        <= 1'b0;
                                    abort_pending <= 1'b0;
                                    last_flag     <= (length_q == CNT_ONE);
                                end
                            end
                        end else if (w_data_q[1]) begin
                            if (beat_last) begin
                                state         <= ST_IDLE;
                                abort_pending <= 1'b0;
                            end else if (pkt_cnt == '0 && !beat) begin
                                state <= ST_IDLE;
                            end else begin
                                abort_pending <= 1'b1;
                            end
                        end
                    end
                    default: s_axi_lite_bresp <= RESP_SLVERR;
                endcase
            end
        end
    end

    // Decode the read address into register contents
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (s_axi_lite_araddr[29:2])
            A_LENGTH: rd_data = 32'(length_q);
            A_PKT:    rd_data = 32'(pkt_cnt);
            A_ITER:   rd_data = 32'(iter_cnt);
            A_NUM:    rd_data = 32'(num_packets_q);
            A_CTRL:   rd_data = {29'd0, abort_pending, done_q, run};
            default:  rd_resp = RESP_SLVERR;
        endcase
    end

    // Register the read response at the AR handshake and hold it until accepted
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_axi_lite_rvalid <= 1'b0;
            s_axi_lite_rdata  <= '0;
            s_axi_lite_rresp  <= RESP_OKAY;
        end else if (s_axi_lite_arvalid && s_axi_lite_arready) begin
            s_axi_lite_rvalid <= 1'b1;
            s_axi_lite_rdata  <= rd_data;
            s_axi_lite_rresp  <= rd_resp;
        end else if (s_axi_lite_rvalid && s_axi_lite_rready) begin
            s_axi_lite_rvalid <= 1'b0;
        end
    end

endmodule
